// File: rtl/rr_sel_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the rr_sel_arbiter slice.
// The optional hand-over dead cycle is selected with the RR_GUARD_EN macro.
package rr_sel_pkg;

  localparam int N_REQ        = 4;
  localparam int SEL_W        = 2;
  localparam int MAX_HOLD_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/rr_sel_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter.
// The arbiter side is the slave modport.
interface rr_sel_arbiter_if;
  import rr_sel_pkg::*;

  logic [N_REQ-1:0] req;
  logic [SEL_W-1:0] sel;
  logic             sel_en;
  logic             rotate;

  modport master (output req, input sel, input sel_en, input rotate);
  modport slave  (input req, output sel, output sel_en, output rotate);

endinterface

// File: rtl/rr_sel_arbiter_pick4.sv
// Combinational round-robin picker: first unmasked request after `last`,
// with `last` itself searched at lowest priority.
module rr_pick4
  import rr_sel_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] winner,
  output logic             found
);

  logic [N_REQ-1:0] cand_s;
  logic [SEL_W-1:0] idx_s;

  assign cand_s = req & ~mask;

  // Scan from lowest to highest priority so the nearest hit after last wins.
  always_comb begin
    winner = 2'b00;
    found  = 1'b0;
    idx_s  = 2'b00;
    for (int k = N_REQ; k >= 1; k--) begin
      idx_s = last + SEL_W'(k);
      if (cand_s[idx_s]) begin
        winner = idx_s;
        found  = 1'b1;
      end else begin
        winner = winner;
        found  = found;
      end
    end
  end

endmodule

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter driving a 2-to-4 decoder select/enable with a hold timer.
// Define RR_GUARD_EN to insert a break-before-make GAP cycle at every hand-over.
module rr_sel_arbiter
  import rr_sel_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  rr_sel_arbiter_if.slave  bus
);

  localparam int              HOLD_W    = $clog2(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t            state_r, state_s;
  logic [SEL_W-1:0]  last_r, last_s;
  logic [SEL_W-1:0]  sel_r, sel_s;
  logic [HOLD_W-1:0] hold_r, hold_s;
  logic              sel_en_r, sel_en_s;
  logic              rotate_r, rotate_s;

  logic [N_REQ-1:0]  mask_s;
  logic [SEL_W-1:0]  winner_s;
  logic              found_s;
  logic              release_s;
  logic              others_s;
  logic              expiry_s;

  // While granted, the current owner is excluded from the search.
  assign mask_s    = (state_r == GRANT) ? onehot(sel_r) : {N_REQ{1'b0}};
  assign release_s = ~bus.req[sel_r];
  assign others_s  = |(bus.req & ~onehot(sel_r));
  assign expiry_s  = (hold_r == HOLD_LAST) && others_s;

  rr_pick4 u_pick (
    .req    (bus.req),
    .mask   (mask_s),
    .last   (last_r),
    .winner (winner_s),
    .found  (found_s)
  );

  // Next-state, pointer, hold counter and output decode.
  always_comb begin
    state_s  = state_r;
    last_s   = last_r;
    sel_s    = sel_r;
    hold_s   = hold_r;
    sel_en_s = sel_en_r;
    rotate_s = 1'b0;
    case (state_r)
      IDLE, GAP: begin
        if (found_s) begin
          state_s  = GRANT;
          sel_s    = winner_s;
          last_s   = winner_s;
          hold_s   = {HOLD_W{1'b0}};
          sel_en_s = 1'b1;
        end else begin
          state_s  = IDLE;
          sel_en_s = 1'b0;
        end
      end
      GRANT: begin
        if (release_s || expiry_s) begin
          // A simultaneous release takes precedence and never rotates.
          rotate_s = expiry_s && !release_s;
          hold_s   = {HOLD_W{1'b0}};
`ifdef RR_GUARD_EN
          state_s  = found_s ? GAP : IDLE;
          sel_en_s = 1'b0;
`else
          if (found_s) begin
            sel_s    = winner_s;
            last_s   = winner_s;
            sel_en_s = 1'b1;
          end else begin
            state_s  = IDLE;
            sel_en_s = 1'b0;
          end
`endif
        end else if (hold_r == HOLD_LAST) begin
          hold_s = {HOLD_W{1'b0}};
        end else begin
          hold_s = hold_r + HOLD_W'(1);
        end
      end
      default: begin
        state_s  = IDLE;
        sel_en_s = 1'b0;
      end
    endcase
  end

  // State and registered outputs, cleared asynchronously.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r  <= IDLE;
      last_r   <= 2'b11;
      sel_r    <= 2'b00;
      hold_r   <= {HOLD_W{1'b0}};
      sel_en_r <= 1'b0;
      rotate_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      last_r   <= last_s;
      sel_r    <= sel_s;
      hold_r   <= hold_s;
      sel_en_r <= sel_en_s;
      rotate_r <= rotate_s;
    end
  end

  assign bus.sel    = sel_r;
  assign bus.sel_en = sel_en_r;
  assign bus.rotate = rotate_r;

endmodule
